// File: rtl/vec_pkg.sv
// Shared vector helpers: lane ordering, width math, lane slicing.
// Used by word_serializer (and a future word_deserializer).
package vec_pkg;

  localparam logic ORDER_LSB_FIRST = 1'b0;
  localparam logic ORDER_MSB_FIRST = 1'b1;

  // Widest word lane_select can slice.
  localparam int LANE_MAX_W = 256;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ser_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Lane `index` (width lane_w) of word, right-aligned and
  // zero above lane_w.
  function automatic logic [LANE_MAX_W-1:0] lane_select(
    input logic [LANE_MAX_W-1:0] word,
    input int                    index,
    input int                    lane_w
  );
    logic [LANE_MAX_W-1:0] mask;
    mask = ~({LANE_MAX_W{1'b1}} << lane_w);
    return (word >> (index * lane_w)) & mask;
  endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Handshake bundle for word_serializer: wide word in, narrow beats out.
// master = producer/consumer side, slave = serializer.
interface word_serializer_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
);
  logic [IN_W-1:0]  in_data;
  logic             in_msb_first;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;

  modport master (
    output in_data, in_msb_first, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_msb_first, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/word_serializer.sv
// Splits an IN_W word into IN_W/OUT_W beats, MSB- or LSB-slice first.
// Ports: clk, rst_n (async low), bus (word_serializer_if.slave).
module word_serializer
  import vec_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  word_serializer_if.slave bus
);

  localparam bit BAD_PARAMS =
    (OUT_W < 1) ? 1'b1 :
    (((IN_W % OUT_W) != 0) || (IN_W > LANE_MAX_W));

  localparam int NBEATS = (OUT_W > 0) ? IN_W / OUT_W : 1;
  localparam int CW     = clog2_min1(NBEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

  if (BAD_PARAMS) begin : g_bad_params
    $error("word_serializer: IN_W must be a multiple of OUT_W >= 1");
  end

  ser_state_e      state_q, state_n;
  logic [CW-1:0]   beat_q, beat_n;
  logic [IN_W-1:0] word_q, word_n;
  logic            mode_q, mode_n;

  logic valid, last;

  assign valid = (state_q == ST_BUSY);
  assign last  = valid && (beat_q == LAST_BEAT);

  // Ready depends only on held state and out_ready.
  assign bus.in_ready  = !valid || (bus.out_ready && last);
  assign bus.out_valid = valid;
  assign bus.out_last  = last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      word_q  <= '0;
      mode_q  <= ORDER_LSB_FIRST;
    end else begin
      state_q <= state_n;
      beat_q  <= beat_n;
      word_q  <= word_n;
      mode_q  <= mode_n;
    end
  end

  always_comb begin
    state_n = state_q;
    beat_n  = beat_q;
    word_n  = word_q;
    mode_n  = mode_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_n = ST_BUSY;
          beat_n  = '0;
          word_n  = bus.in_data;
          mode_n  = bus.in_msb_first;
        end
      end
      ST_BUSY: begin
        if (bus.out_ready) begin
          if (last) begin
            beat_n = '0;
            if (bus.in_valid) begin
              word_n = bus.in_data;
              mode_n = bus.in_msb_first;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            beat_n = beat_q + CW'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Output comes purely from held word/mode/counter.
  logic [LANE_MAX_W-1:0] word_ext;
  logic [LANE_MAX_W-1:0] lane;
  int                    idx;

  always_comb begin
    word_ext            = '0;
    word_ext[IN_W-1:0]  = word_q;
    idx = (mode_q == ORDER_MSB_FIRST) ?
          (NBEATS - 1 - int'(beat_q)) : int'(beat_q);
    lane = lane_select(word_ext, idx, OUT_W);
  end

  assign bus.out_data = lane[OUT_W-1:0];

  logic unused_lane;
  assign unused_lane = ^lane[LANE_MAX_W-1:OUT_W];

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: 16/8, 32/8 and 8/8 configs.
// Table vectors for 16/8 plus hand sequences for corner cases.
module tb_word_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  word_serializer_if #(.IN_W(16), .OUT_W(8)) bus_a ();
  word_serializer_if #(.IN_W(32), .OUT_W(8)) bus_b ();
  word_serializer_if #(.IN_W(8),  .OUT_W(8)) bus_c ();

  word_serializer #(.IN_W(16), .OUT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  word_serializer #(.IN_W(32), .OUT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  word_serializer #(.IN_W(8),  .OUT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        m;
    logic        ordy;
    logic        ev;
    logic [7:0]  ed;
    logic        el;
    logic        er;
  } vec_t;

  vec_t tv[$];

  function automatic void add(logic iv, logic [15:0] d, logic m,
                              logic ordy, logic ev, logic [7:0] ed,
                              logic el, logic er);
    vec_t v;
    v.iv = iv; v.d = d; v.m = m; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.el = el; v.er = er;
    tv.push_back(v);
  endfunction

  task automatic run_b(input logic [31:0] w, input logic m,
                       input logic [31:0] exp);
    logic [31:0] e;
    e = exp;
    @(negedge clk);
    bus_b.in_valid = 1'b1;
    bus_b.in_data = w;
    bus_b.in_msb_first = m;
    bus_b.out_ready = 1'b1;
    #1 chk("b_ready_idle", 32'(bus_b.in_ready), 32'd1);
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    bus_b.in_msb_first = ~m;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("b_valid%0d", i), 32'(bus_b.out_valid), 32'd1);
      chk($sformatf("b_data%0d", i), 32'(bus_b.out_data),
          32'(e[31-8*i -: 8]));
      chk($sformatf("b_last%0d", i), 32'(bus_b.out_last),
          32'(i == 3));
      @(negedge clk);
    end
    #1 chk("b_idle", 32'(bus_b.out_valid), 32'd0);
  endtask

  initial begin
    bus_a.in_valid = 0; bus_a.in_data = '0;
    bus_a.in_msb_first = 0; bus_a.out_ready = 0;
    bus_b.in_valid = 0; bus_b.in_data = '0;
    bus_b.in_msb_first = 0; bus_b.out_ready = 0;
    bus_c.in_valid = 0; bus_c.in_data = '0;
    bus_c.in_msb_first = 0; bus_c.out_ready = 0;

    // MSB first 0xABCD
    add(1, 16'hABCD, 1, 1, 0, 8'h00, 0, 1);
    add(0, 16'h0000, 0, 1, 1, 8'hAB, 0, 0);
    add(0, 16'h0000, 0, 1, 1, 8'hCD, 1, 1);
    add(0, 16'h0000, 0, 1, 0, 8'h00, 0, 1);
    // LSB first 0xABCD
    add(1, 16'hABCD, 0, 1, 0, 8'h00, 0, 1);
    add(0, 16'h0000, 1, 1, 1, 8'hCD, 0, 0);
    add(0, 16'h0000, 1, 1, 1, 8'hAB, 1, 1);
    add(0, 16'h0000, 0, 1, 0, 8'h00, 0, 1);
    // back-to-back 0x1234, 0x5678
    add(1, 16'h1234, 1, 1, 0, 8'h00, 0, 1);
    add(1, 16'h5678, 1, 1, 1, 8'h12, 0, 0);
    add(1, 16'h5678, 1, 1, 1, 8'h34, 1, 1);
    add(0, 16'h0000, 0, 1, 1, 8'h56, 0, 0);
    add(0, 16'h0000, 0, 1, 1, 8'h78, 1, 1);
    add(0, 16'h0000, 0, 1, 0, 8'h00, 0, 1);
    // backpressure on first beat
    add(1, 16'hABCD, 1, 1, 0, 8'h00, 0, 1);
    add(0, 16'h0000, 0, 0, 1, 8'hAB, 0, 0);
    add(0, 16'h0000, 0, 0, 1, 8'hAB, 0, 0);
    add(0, 16'h0000, 0, 0, 1, 8'hAB, 0, 0);
    add(0, 16'h0000, 0, 1, 1, 8'hAB, 0, 0);
    add(0, 16'h0000, 0, 1, 1, 8'hCD, 1, 1);
    add(0, 16'h0000, 0, 1, 0, 8'h00, 0, 1);
    // stalled last beat blocks the next word
    add(1, 16'hABCD, 0, 1, 0, 8'h00, 0, 1);
    add(0, 16'h0000, 0, 1, 1, 8'hCD, 0, 0);
    add(1, 16'h00FF, 1, 0, 1, 8'hAB, 1, 0);
    add(1, 16'h00FF, 1, 1, 1, 8'hAB, 1, 1);
    add(0, 16'h0000, 0, 1, 1, 8'h00, 0, 0);
    add(0, 16'h0000, 0, 1, 1, 8'hFF, 1, 1);
    add(0, 16'h0000, 0, 1, 0, 8'h00, 0, 1);

    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rst_last",  32'(bus_a.out_last),  32'd0);
    chk("rst_data",  32'(bus_a.out_data),  32'd0);
    chk("rst_ready", 32'(bus_a.in_ready),  32'd1);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      @(negedge clk);
      bus_a.in_valid = tv[i].iv;
      bus_a.in_data = tv[i].d;
      bus_a.in_msb_first = tv[i].m;
      bus_a.out_ready = tv[i].ordy;
      #1;
      chk($sformatf("a%0d_valid", i), 32'(bus_a.out_valid),
          32'(tv[i].ev));
      chk($sformatf("a%0d_ready", i), 32'(bus_a.in_ready),
          32'(tv[i].er));
      chk($sformatf("a%0d_last", i), 32'(bus_a.out_last),
          32'(tv[i].el));
      if (tv[i].ev)
        chk($sformatf("a%0d_data", i), 32'(bus_a.out_data),
            32'(tv[i].ed));
    end

    // 32/8 both orders
    run_b(32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
    run_b(32'hDEADBEEF, 1'b0, 32'hEFBEADDE);

    // 8/8: single-beat words, full throughput
    @(negedge clk);
    bus_c.out_ready = 1'b1;
    bus_c.in_valid = 1'b1;
    bus_c.in_data = 8'h5A;
    @(negedge clk);
    bus_c.in_data = 8'hC3;
    #1;
    chk("c0_valid", 32'(bus_c.out_valid), 32'd1);
    chk("c0_data",  32'(bus_c.out_data),  32'h5A);
    chk("c0_last",  32'(bus_c.out_last),  32'd1);
    chk("c0_ready", 32'(bus_c.in_ready),  32'd1);
    @(negedge clk);
    bus_c.in_valid = 1'b0;
    #1;
    chk("c1_data",  32'(bus_c.out_data),  32'hC3);
    chk("c1_last",  32'(bus_c.out_last),  32'd1);
    @(negedge clk);
    #1 chk("c2_valid", 32'(bus_c.out_valid), 32'd0);

    // async reset mid-word
    @(negedge clk);
    bus_a.in_valid = 1'b1;
    bus_a.in_data = 16'hABCD;
    bus_a.in_msb_first = 1'b1;
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    #1 chk("mr_beat0", 32'(bus_a.out_data), 32'hAB);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(bus_a.out_valid), 32'd0);
    chk("mr_last",  32'(bus_a.out_last),  32'd0);
    chk("mr_data",  32'(bus_a.out_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mr_ready", 32'(bus_a.in_ready), 32'd1);
    @(negedge clk);
    bus_a.in_valid = 1'b1;
    bus_a.in_data = 16'h00FF;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    #1;
    chk("mr_n0_valid", 32'(bus_a.out_valid), 32'd1);
    chk("mr_n0_data",  32'(bus_a.out_data),  32'h00);
    chk("mr_n0_last",  32'(bus_a.out_last),  32'd0);
    @(negedge clk);
    #1;
    chk("mr_n1_data",  32'(bus_a.out_data),  32'hFF);
    chk("mr_n1_last",  32'(bus_a.out_last),  32'd1);
    @(negedge clk);
    #1 chk("mr_idle", 32'(bus_a.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
